// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider: FSM state encoding and
// handshake levels seen by the EX stage.
package div_pkg;

  localparam int DATA_W_DEF = 32;

  // FSM encoding matches the legacy DivFree/DivByZero/DivOn/DivEnd values.
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // EX-side request levels.
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // Responder-side result status.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (combinational).
// Kept standalone so it can be unit-tested and replicated for higher radix.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_i,      // {partial remainder, next dividend bit}
  input  logic [DATA_W-1:0] divisor_i,  // divisor magnitude
  output logic [DATA_W-1:0] rem_o,      // new partial remainder
  output logic              q_o         // quotient bit produced this step
);

  logic [DATA_W:0] trial;

  // The partial remainder is always below the divisor, so rem_i < 2*divisor
  // and the top bit of the 33-bit difference is exactly the borrow.
  assign trial = rem_i - {1'b0, divisor_i};
  assign q_o   = ~trial[DATA_W];
  assign rem_o = q_o ? trial[DATA_W-1:0] : rem_i[DATA_W-1:0];

endmodule

// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned restoring divider, responder side of the
// EX-stage divide handshake. Returns {remainder, quotient}.
// Optional feature macro: DIV_EARLY_FINISH_EN -- when defined, a non-zero
// divisor whose magnitude exceeds the dividend's finishes in two edges.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int              CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   dvd_q;     // dividend magnitude, consumed MSB first
  logic [DATA_W-1:0]   dvs_q;     // divisor magnitude
  logic [DATA_W-1:0]   rem_q;     // partial remainder
  logic [DATA_W-1:0]   quo_q;     // quotient bits shifted in LSB first
  logic                signed_q;
  logic                sign1_q;
  logic                sign2_q;
  logic                ready_q;
  logic [2*DATA_W-1:0] result_q;

  logic                neg1;
  logic                neg2;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   quo_d;
  logic                q_bit;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   quo_fix;

  // Operand magnitudes: two's-complement absolute value for negative signed inputs.
  assign neg1 = signed_div_i & opdata1_i[DATA_W-1];
  assign neg2 = signed_div_i & opdata2_i[DATA_W-1];
  assign mag1 = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign mag2 = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     ({rem_q, dvd_q[DATA_W-1]}),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .q_o       (q_bit)
  );

  assign quo_d = {quo_q[DATA_W-2:0], q_bit};

  // Sign fixup: quotient negative when signs differ, remainder follows the dividend.
  assign quo_fix = (signed_q & (sign1_q ^ sign2_q)) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = (signed_q & sign1_q) ? (~rem_q + 1'b1) : rem_q;

  // Divider FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state here uses <= so every register samples pre-edge values.
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      signed_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      ready_q  <= DIV_RESULT_NOT_READY;
      result_q <= '0;
    end else begin
      unique case (state_q)
        DIV_FREE: begin
          ready_q  <= DIV_RESULT_NOT_READY;
          result_q <= '0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
`ifdef DIV_EARLY_FINISH_EN
            end else if (mag1 < mag2) begin
              state_q  <= DIV_END;
              ready_q  <= DIV_RESULT_READY;
              result_q <= {opdata1_i, {DATA_W{1'b0}}};
`endif
            end else begin
              state_q  <= DIV_ON;
              dvd_q    <= mag1;
              dvs_q    <= mag2;
              rem_q    <= '0;
              quo_q    <= '0;
              cnt_q    <= '0;
              signed_q <= signed_div_i;
              sign1_q  <= opdata1_i[DATA_W-1];
              sign2_q  <= opdata2_i[DATA_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          if (annul_i) begin
            state_q <= DIV_FREE;
          end else begin
            state_q  <= DIV_END;
            ready_q  <= DIV_RESULT_READY;
            result_q <= '0;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state_q  <= DIV_FREE;
            ready_q  <= DIV_RESULT_NOT_READY;
            result_q <= '0;
          end else if (cnt_q == LAST_CNT) begin
            state_q  <= DIV_END;
            ready_q  <= DIV_RESULT_READY;
            result_q <= {rem_fix, quo_fix};
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DIV_END: begin
          if (annul_i || start_i == DIV_STOP) begin
            state_q  <= DIV_FREE;
            ready_q  <= DIV_RESULT_NOT_READY;
            result_q <= '0;
          end
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the multi-cycle divider: directed and random
// divides scored through an expected-result queue, plus handshake, annul
// and asynchronous-reset scenarios.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic (truncating division).
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    if (b == 32'd0) return 2;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_FINISH_EN
    if (ma < mb) return 2;
`else
    if (ma < mb) return 34;
`endif
    return 34;
  endfunction

  // Full handshake: request, wait for ready, hold, release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res);
    exp_t e;
    int   edges;
    sb_q.push_back('{res: exp_res, lat: exp_lat(sgn, a, b)});
    @(negedge clk);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    edges      = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        op1        = $urandom;
        op2        = $urandom;
        signed_div = ~sgn;
      end
    end while (!ready && edges < 100);
    e = sb_q.pop_front();
    check({tag, " latency"}, 64'(edges), 64'(e.lat));
    check({tag, " result"}, result, e.res);
    repeat (5) @(negedge clk);
    check({tag, " held ready"}, {63'd0, ready}, 64'd1);
    check({tag, " held result"}, result, e.res);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " drop ready"}, {63'd0, ready}, 64'd0);
    check({tag, " drop result"}, result, 64'd0);
  endtask

  initial begin
    logic        seen;
    int          edges;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    #12;
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_div("u5/0", 1'b0, 32'd5, 32'd0, 64'd0);
    run_div("s5/0", 1'b1, 32'd5, 32'd0, 64'd0);
    run_div("s-5/5", 1'b1, 32'hFFFF_FFFB, 32'd5, {32'd0, 32'hFFFF_FFFF});
    run_div("umax/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
    run_div("u3/10", 1'b0, 32'd3, 32'd10, {32'd3, 32'd0});
    run_div("s-3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, {32'hFFFF_FFFD, 32'd0});
    run_div("u0/9", 1'b0, 32'd0, 32'd9, 64'd0);

    // Annul on edge 10 of a 1000/3 divide.
    @(negedge clk);
    signed_div = 1'b0;
    op1        = 32'd1000;
    op2        = 32'd3;
    start      = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready;
    end
    check("annul no ready", {63'd0, seen}, 64'd0);
    check("annul result", result, 64'd0);
    run_div("u9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // start and annul together in FREE must not accept.
    @(negedge clk);
    op1   = 32'd50;
    op2   = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready;
    end
    check("start+annul no ready", {63'd0, seen}, 64'd0);
    start = 1'b0;
    annul = 1'b0;

    // Asynchronous reset in the middle of an iteration run.
    @(negedge clk);
    op1   = 32'd1000;
    op2   = 32'd3;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_on ready", {63'd0, ready}, 64'd0);
    check("rst_on result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    op1   = 32'd12;
    op2   = 32'd4;
    start = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!ready && edges < 100);
    check("rst_end ready before", {63'd0, ready}, 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_end ready", {63'd0, ready}, 64'd0);
    check("rst_end result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random operands scored against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) rb = rb >> 24;
      if (i % 3 == 2) ra = ra >> 8;
      rs = i[0];
      run_div("rand", rs, ra, rb, model(rs, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit integer divider. It is the responder side of the EX-stage divide handshake.
- EX drives the operands, the signed/unsigned flag and `start_i`. It holds start high and stalls until `ready_o` is seen.
- The block returns {remainder, quotient}; EX writes these to HI/LO.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- `DATA_W`, 32, operand width. Iteration count equals `DATA_W`; `result_o` width is 2*`DATA_W`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high (RstEnable = 1'b1).
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  `DATA_W`  dividend.
- `opdata2_i`  in  `DATA_W`  divisor.
- `start_i`  in  1  DivStart/DivStop request from EX.
- `annul_i`  in  1  cancel an in-flight divide (flush or exception).
- `result_o`  out  2*`DATA_W`  [63:32] remainder (HI), [31:0] quotient (LO).
- `ready_o`  out  1  DivResultReady/DivResultNotReady.

Behaviour:
- Reset (async, any state): state=FREE, `ready_o`=0, `result_o`=0, counter=0, internal registers=0. Reset mid-operation discards all work.
- FREE:
  - `start_i`=1 and `annul_i`=0 and divisor=0 -> BYZERO.
  - `start_i`=1 and `annul_i`=0 and divisor!=0 -> ON. On this edge: latch the operand magnitudes (two's-complement absolute value when `signed_div_i`=1 and the sign bit is set), latch `signed_div_i` and both sign bits, clear the partial remainder, set counter=0.
  - `annul_i` has priority over `start_i`; if both are high, stay in FREE.
- BYZERO: next edge -> END with quotient=0 and remainder=0.
- ON, one iteration per edge while `annul_i`=0:
  - trial = {partial remainder, next dividend bit} minus divisor magnitude, in 33-bit arithmetic.
  - If the borrow is clear, keep trial as the new remainder and shift in quotient bit 1; otherwise shift in 0.
  - Counter increments each iteration.
- ON, fixup: when counter reaches `DATA_W` the next edge goes to END.
  - Negate the quotient if signed and the sign bits differ.
  - Negate the remainder if signed and the dividend was negative (remainder takes the dividend's sign).
- ON, abort: `annul_i`=1 on any edge -> FREE, `ready_o` stays 0, `result_o`=0. `start_i` is ignored while ON.
- END:
  - `ready_o`=1 and `result_o` are held stable while `start_i`=1.
  - First edge with `start_i`=0 -> FREE, `ready_o`=0, `result_o`=0.
  - `annul_i` in END also -> FREE.
- Operand inputs are sampled only at acceptance; later changes are ignored.
- Latency: counting the accept edge as edge 1, `ready_o` is high after edge 34 (1 accept + 32 iterations + 1 fixup). Divide-by-zero gives `ready_o` high after edge 2.
- Overflow case, signed -2^31 / -1: quotient=0x80000000, remainder=0, no trap.
- Only `ready_o` and `result_o` are visible outputs; both are registered, with no combinational input-to-output path.

Optional Feature:
- Macro: `DIV_EARLY_FINISH_EN`.
- Defined: in FREE, if divisor!=0 and |dividend| < |divisor| (unsigned compare of magnitudes), go directly to END with quotient=0 and remainder=dividend as presented (sign preserved). `ready_o` is high after edge 2; a dividend of 0 takes this path.
- Not defined: every non-zero divisor takes the full 34-edge path; results are identical in both builds.

Decomposition:
- defines.v constants:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivStart/DivStop, DivResultReady/DivResultNotReady.
  - RstEnable, ZeroWord, RegBus, DoubleRegBus.
- Sub-module: `div_step`, combinational, one restoring iteration.
  - Inputs: 33-bit partial remainder, divisor magnitude.
  - Outputs: new remainder, quotient bit.
  - Kept separate so the step can be unit-tested and later duplicated for radix-4.

Test Plan:
- Unsigned 100/7, start held high -> `ready_o` rises after edge 34; `result_o` = {32'd2, 32'd14}; stays stable until start drops.
- Signed -7/2 (0xFFFFFFF9 / 2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed -2^31/-1 -> {32'h0, 32'h80000000}.
- 5/0 (either signedness) -> `ready_o` after edge 2; `result_o` = 0.
- `annul_i` pulsed on edge 10 of a 1000/3 divide -> `ready_o` never rises and state returns to FREE. Then 9/3 -> {0, 3} after 34 edges.
- END handshake: hold start 5 extra cycles -> `ready_o`=1 and result constant. Drop start -> after the next edge `ready_o`=0 and `result_o`=0. Assert start+annul together in FREE -> no accept.
- `rst` asserted mid-ON (asynchronously, between edges) -> `ready_o`/`result_o` go to 0 immediately. With `DIV_EARLY_FINISH_EN`: 3/10 -> {3, 0} after edge 2; unsigned -> 34 edges without the macro.
